// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler for NUM_CH HC-SR04-class sensors on one shared trigger/echo/cm datapath.
// Each shot runs trigger, echo timing, cm conversion, result hold and an inter-shot guard.
module ultrasonic_scan_scheduler #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TRIG_CYC    = 1000,
  parameter int unsigned US_CYC      = 100,
  parameter int unsigned CM_US       = 58,
  parameter int unsigned MAX_CM      = 400,
  parameter int unsigned RISE_TO_CYC = 3_000_000,
  parameter int unsigned GUARD_CYC   = 6_000_000,
  localparam int unsigned CW         = $clog2(NUM_CH),
  localparam int unsigned DW         = $clog2(MAX_CM + 1)
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              enable_i,
  input  logic              oneshot_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic [NUM_CH-1:0] echo_i,
  output logic [NUM_CH-1:0] trig_o,
  output logic              busy_o,
  output logic              res_valid_o,
  output logic [CW-1:0]     res_ch_o,
  output logic [DW-1:0]     res_dist_o,
  output logic              res_err_o,
  input  logic [CW-1:0]     rd_ch_i,
  output logic [DW-1:0]     rd_dist_o,
  output logic              rd_err_o
);

  localparam int unsigned CNT_MAX_A = (TRIG_CYC > RISE_TO_CYC) ? TRIG_CYC : RISE_TO_CYC;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > GUARD_CYC) ? CNT_MAX_A : GUARD_CYC;
  localparam int unsigned CNTW      = $clog2(CNT_MAX + 1);
  localparam int unsigned USW       = $clog2(US_CYC + 1);
  localparam int unsigned TKW       = $clog2(CM_US + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GUARD
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cur_q, cur_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [USW-1:0]      us_q, us_d;
  logic [TKW-1:0]      tk_q, tk_d;
  logic [DW-1:0]       cm_q, cm_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   trig_q, trig_d;
  logic                busy_q;
  logic                res_valid_q;
  logic [CW-1:0]       res_ch_q;
  logic [DW-1:0]       res_dist_q;
  logic                res_err_q;
  logic [NUM_CH-1:0]   echo_s1_q, echo_s2_q, echo_s3_q;
  logic [DW-1:0]       hold_dist_q [NUM_CH];
  logic                hold_err_q  [NUM_CH];

  logic [NUM_CH-1:0]   cand_c;
  logic                found_c;
  logic [CW-1:0]       next_c;
  logic                rise_c, fall_c;
  logic                us_wrap_c, cm_inc_c;
  logic                done_c;
  logic [DW-1:0]       done_dist_c;
  logic                done_err_c;

  // Edges are taken on the synchronised echo of the channel being measured
  assign rise_c    = echo_s2_q[cur_q] & ~echo_s3_q[cur_q];
  assign fall_c    = ~echo_s2_q[cur_q] & echo_s3_q[cur_q];
  assign us_wrap_c = (us_q == USW'(US_CYC - 1));
  assign cm_inc_c  = us_wrap_c && (tk_q == TKW'(CM_US - 1));

  // Next channel: first candidate strictly after cur, wrapping back to cur last
  always_comb begin
    cand_c  = enable_i ? (ch_mask_i | pending_q) : pending_q;
    found_c = 1'b0;
    next_c  = cur_q;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      if (!found_c && cand_c[CW'((32'(cur_q) + i) % NUM_CH)]) begin
        found_c = 1'b1;
        next_c  = CW'((32'(cur_q) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q + CNTW'(1);
    us_d        = us_q;
    tk_d        = tk_q;
    cm_d        = cm_q;
    done_c      = 1'b0;
    done_dist_c = '0;
    done_err_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if ((enable_i && (ch_mask_i != '0)) || (pending_q != '0)) state_d = S_SELECT;
      end
      S_SELECT: begin
        cnt_d = '0;
        if (found_c) begin
          cur_d   = next_c;
          state_d = S_TRIG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG: begin
        if (cnt_q == CNTW'(TRIG_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_RISE;
        end
      end
      S_WAIT_RISE: begin
        if (rise_c) begin
          state_d = S_MEASURE;
          us_d    = '0;
          tk_d    = '0;
          cm_d    = '0;
        end else if (cnt_q == CNTW'(RISE_TO_CYC - 1)) begin
          done_c     = 1'b1;
          done_err_c = 1'b1;
        end
      end
      S_MEASURE: begin
        cnt_d = '0;
        us_d  = us_wrap_c ? '0 : us_q + USW'(1);
        if (us_wrap_c) tk_d = (tk_q == TKW'(CM_US - 1)) ? '0 : tk_q + TKW'(1);
        // The current cycle's increment counts toward a fall result; fall beats overflow
        if (fall_c) begin
          done_c      = 1'b1;
          done_dist_c = (cm_inc_c && (cm_q != DW'(MAX_CM))) ? cm_q + DW'(1) : cm_q;
        end else if (cm_inc_c) begin
          if (cm_q == DW'(MAX_CM)) begin
            done_c      = 1'b1;
            done_dist_c = DW'(MAX_CM);
            done_err_c  = 1'b1;
          end else begin
            cm_d = cm_q + DW'(1);
          end
        end
      end
      S_GUARD: begin
        if (cnt_q == CNTW'(GUARD_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_SELECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done_c) begin
      cnt_d   = '0;
      state_d = S_GUARD;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (done_c) pending_d[cur_q] = 1'b0;
    if (oneshot_i) pending_d = pending_d | ch_mask_i;
  end

  assign trig_d = (state_d == S_TRIG) ? (NUM_CH'(1) << cur_d) : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      cur_q       <= CW'(NUM_CH - 1);
      cnt_q       <= '0;
      us_q        <= '0;
      tk_q        <= '0;
      cm_q        <= '0;
      pending_q   <= '0;
      trig_q      <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_dist_q  <= '0;
      res_err_q   <= 1'b0;
      echo_s1_q   <= '0;
      echo_s2_q   <= '0;
      echo_s3_q   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        hold_dist_q[i] <= '0;
        hold_err_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      us_q        <= us_d;
      tk_q        <= tk_d;
      cm_q        <= cm_d;
      pending_q   <= pending_d;
      trig_q      <= trig_d;
      busy_q      <= (state_d != S_IDLE);
      res_valid_q <= done_c;
      echo_s1_q   <= echo_i;
      echo_s2_q   <= echo_s1_q;
      echo_s3_q   <= echo_s2_q;
      if (done_c) begin
        res_ch_q           <= cur_q;
        res_dist_q         <= done_dist_c;
        res_err_q          <= done_err_c;
        hold_dist_q[cur_q] <= done_dist_c;
        hold_err_q[cur_q]  <= done_err_c;
      end
    end
  end

  assign trig_o      = trig_q;
  assign busy_o      = busy_q;
  assign res_valid_o = res_valid_q;
  assign res_ch_o    = res_ch_q;
  assign res_dist_o  = res_dist_q;
  assign res_err_o   = res_err_q;
  assign rd_dist_o   = hold_dist_q[rd_ch_i];
  assign rd_err_o    = hold_err_q[rd_ch_i];

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Self-checking bench for ultrasonic_scan_scheduler: directed scenarios plus randomized echo
// widths and masks, checked against a pulse-width/round-robin reference model.
module tb_ultrasonic_scan_scheduler;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned TRIG_CYC    = 10;
  localparam int unsigned US_CYC      = 2;
  localparam int unsigned CM_US       = 3;
  localparam int unsigned MAX_CM      = 20;
  localparam int unsigned RISE_TO_CYC = 200;
  localparam int unsigned GUARD_CYC   = 50;
  localparam int          CYC_PER_CM  = US_CYC * CM_US;
  localparam int          OVF_CYC     = (MAX_CM + 1) * CYC_PER_CM;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       enable = 1'b0;
  logic       oneshot = 1'b0;
  logic [3:0] ch_mask = 4'b0;
  logic [3:0] echo = 4'b0;
  logic [1:0] rd_ch = 2'b0;
  logic [3:0] trig;
  logic       busy, res_valid, res_err, rd_err;
  logic [1:0] res_ch;
  logic [4:0] res_dist, rd_dist;

  int checks = 0;
  int errors = 0;
  int model_dist [NUM_CH];
  int model_err  [NUM_CH];
  int cur_model;
  int rv_count = 0;
  int multi_cnt = 0;
  int trig2_cnt = 0;

  always #5 PCLK = ~PCLK;

  ultrasonic_scan_scheduler #(
    .NUM_CH(NUM_CH), .TRIG_CYC(TRIG_CYC), .US_CYC(US_CYC), .CM_US(CM_US),
    .MAX_CM(MAX_CM), .RISE_TO_CYC(RISE_TO_CYC), .GUARD_CYC(GUARD_CYC)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .enable_i(enable), .oneshot_i(oneshot),
    .ch_mask_i(ch_mask), .echo_i(echo), .trig_o(trig), .busy_o(busy),
    .res_valid_o(res_valid), .res_ch_o(res_ch), .res_dist_o(res_dist),
    .res_err_o(res_err), .rd_ch_i(rd_ch), .rd_dist_o(rd_dist), .rd_err_o(rd_err)
  );

  always @(negedge PCLK) begin
    if ($countones(trig) > 1) multi_cnt++;
    if (trig[2] === 1'b1) trig2_cnt++;
    if (res_valid === 1'b1) rv_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: echo high for hi cycles (0 = no echo at all)
  function automatic int exp_dist(input int hi);
    if (hi == 0) return 0;
    if (hi > OVF_CYC) return MAX_CM;
    return (hi / CYC_PER_CM > MAX_CM) ? MAX_CM : hi / CYC_PER_CM;
  endfunction

  function automatic int exp_err(input int hi);
    return ((hi == 0) || (hi > OVF_CYC)) ? 1 : 0;
  endfunction

  function automatic int next_ch(input int cur, input logic [3:0] cand);
    for (int k = 1; k <= NUM_CH; k++)
      if (cand[(cur + k) % NUM_CH]) return (cur + k) % NUM_CH;
    return -1;
  endfunction

  function automatic int trig_index(input logic [3:0] t);
    for (int k = 0; k < NUM_CH; k++)
      if (t[k] === 1'b1) return k;
    return -1;
  endfunction

  task automatic do_reset();
    enable = 1'b0; oneshot = 1'b0; ch_mask = 4'b0; echo = 4'b0;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_dist", res_dist, 0);
    chk("rst_res_err", res_err, 0);
    for (int c = 0; c < NUM_CH; c++) begin
      rd_ch = 2'(c);
      #1;
      chk("rst_rd_dist", rd_dist, 0);
      model_dist[c] = 0;
      model_err[c]  = 0;
    end
    PRESET = 1'b0;
    cur_model = NUM_CH - 1;
    @(negedge PCLK);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 500) begin @(negedge PCLK); t++; end
    chk("idle", busy, 0);
  endtask

  task automatic pulse_oneshot(input logic [3:0] m);
    ch_mask = m; oneshot = 1'b1;
    @(negedge PCLK);
    oneshot = 1'b0; ch_mask = 4'b0;
  endtask

  // One shot: expect trig on exp_ch, echo rises delay cycles after trig fall for hi cycles
  task automatic do_shot(input int exp_ch, input int delay, input int hi);
    int t, w, n;
    t = 0;
    while (trig === 4'b0 && t < 400) begin @(negedge PCLK); t++; end
    chk("trig_ch", trig_index(trig), exp_ch);
    w = 0;
    while (trig !== 4'b0 && w < 50) begin @(negedge PCLK); w++; end
    chk("trig_width", w, TRIG_CYC);
    if (hi == 0) begin
      n = 1;
      while (res_valid !== 1'b1 && n < 400) begin @(negedge PCLK); n++; end
      chk("timeout_latency", n - 1, RISE_TO_CYC);
    end else begin
      repeat (delay) @(negedge PCLK);
      echo[exp_ch] = 1'b1;
      n = 0;
      while (res_valid !== 1'b1 && n < 400) begin
        @(negedge PCLK);
        n++;
        if (n == hi) echo[exp_ch] = 1'b0;
      end
      echo[exp_ch] = 1'b0;
    end
    model_dist[exp_ch] = exp_dist(hi);
    model_err[exp_ch]  = exp_err(hi);
    chk("res_valid", res_valid, 1);
    chk("res_ch", res_ch, exp_ch);
    chk("res_dist", res_dist, model_dist[exp_ch]);
    chk("res_err", res_err, model_err[exp_ch]);
    rd_ch = 2'(exp_ch);
    #1;
    chk("rd_dist", rd_dist, model_dist[exp_ch]);
    chk("rd_err", rd_err, model_err[exp_ch]);
    @(negedge PCLK);
    chk("res_valid_pulse", res_valid, 0);
    chk("res_dist_hold", res_dist, model_dist[exp_ch]);
    cur_model = exp_ch;
  endtask

  initial begin
    int t, rv0, tr0, ex;
    logic [3:0] m;
    int order [5] = '{0, 1, 3, 0, 1};

    // T1-T3 single channel: nominal, timeout, stuck-high overflow, guard spacing, cm boundaries
    do_reset();
    ch_mask = 4'b0001; enable = 1'b1;
    do_shot(0, 5, 60);
    do_shot(0, 0, 0);
    do_shot(0, 2, 300);
    t = 0;
    while (trig === 4'b0 && t < 200) begin @(negedge PCLK); t++; end
    chk("guard_gap", t, GUARD_CYC);
    do_shot(0, 0, 5);
    do_shot(0, 3, 6);
    do_shot(0, 1, 126);
    do_shot(0, 1, 127);
    enable = 1'b0;
    wait_idle();

    // Random masks and echo widths in continuous mode
    do_reset();
    m = 4'($urandom_range(1, 15));
    ch_mask = m; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ex = next_ch(cur_model, m);
      do_shot(ex, $urandom_range(0, 120), $urandom_range(1, 135));
      m = 4'($urandom_range(1, 15));
      ch_mask = m;
    end
    enable = 1'b0;
    wait_idle();

    // T4 mask 1011 order and trig exclusivity
    do_reset();
    tr0 = trig2_cnt;
    ch_mask = 4'b1011; enable = 1'b1;
    for (int i = 0; i < 5; i++) do_shot(order[i], $urandom_range(0, 40), $urandom_range(1, 120));
    enable = 1'b0;
    wait_idle();
    chk("trig2_never", trig2_cnt - tr0, 0);

    // T5 oneshot passes, including a mid-pass extension
    do_reset();
    pulse_oneshot(4'b0110);
    do_shot(1, $urandom_range(0, 40), $urandom_range(1, 120));
    pulse_oneshot(4'b1000);
    do_shot(2, $urandom_range(0, 40), $urandom_range(1, 120));
    do_shot(3, $urandom_range(0, 40), $urandom_range(1, 120));
    wait_idle();
    rv0 = rv_count;
    pulse_oneshot(4'b0110);
    do_shot(1, $urandom_range(0, 40), $urandom_range(1, 120));
    do_shot(2, $urandom_range(0, 40), $urandom_range(1, 120));
    wait_idle();
    repeat (20) @(negedge PCLK);
    chk("oneshot_result_count", rv_count - rv0, 2);
    chk("oneshot_idle", busy, 0);

    // T6 reset in the middle of a trigger pulse
    do_reset();
    ch_mask = 4'b1111; enable = 1'b1;
    do_shot(0, 4, 40);
    do_shot(1, 4, 70);
    t = 0;
    while (trig === 4'b0 && t < 400) begin @(negedge PCLK); t++; end
    chk("t6_trig_ch", trig_index(trig), 2);
    repeat (3) @(negedge PCLK);
    rv0 = rv_count;
    #2 PRESET = 1'b1;
    #1;
    chk("t6_trig_async", trig, 0);
    chk("t6_busy_async", busy, 0);
    repeat (2) @(negedge PCLK);
    for (int c = 0; c < NUM_CH; c++) begin
      rd_ch = 2'(c);
      #1;
      chk("t6_rd_dist", rd_dist, 0);
      chk("t6_rd_err", rd_err, 0);
      model_dist[c] = 0;
      model_err[c]  = 0;
    end
    PRESET = 1'b0;
    t = 0;
    while (trig === 4'b0 && t < 400) begin @(negedge PCLK); t++; end
    chk("t6_no_result", rv_count - rv0, 0);
    do_shot(0, 2, 33);
    enable = 1'b0;
    wait_idle();

    chk("never_two_trigs", multi_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
